mt9d111_sccb_config: RTL and testbench

MT9D111_SCCB_CONFIG -- requirements
Module: mt9d111_sccb_config

---
 rtl/mt9d111_pkg.sv | 39 +++
 rtl/mt9d111_init_rom.sv | 21 ++
 rtl/mt9d111_sccb_config.sv | 276 +++++++++++++++++++++++++++
 tb/tb_mt9d111_sccb_config.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mt9d111_pkg.sv
// Shared definitions for the MT9D111 SCCB register-init block.
// Optional feature macro: SCCB_ACK_CHECK_EN (adds NACK retry and the error state).
package mt9d111_pkg;

    localparam logic [7:0]  SCCB_DEV_ADDR = 8'hBA;
    // Must match the number of rows in mt9d111_init_rom (1..256).
    localparam int unsigned INIT_LEN      = 3;

    typedef struct packed {
        logic [7:0]  reg_addr;
        logic [15:0] reg_data;
    } init_entry_t;

    typedef enum logic [3:0] {
        StIdle,
        StPwrWait,
        StLoad,
        StSta,
        StBit,
        StAck,
        StStp,
        StGap,
        StDone
`ifdef SCCB_ACK_CHECK_EN
        , StErr
`endif
    } sccb_state_e;

    // Busy everywhere except the resting states.
    function automatic logic state_busy(input sccb_state_e s);
        logic busy;
        busy = (s != StIdle) && (s != StDone);
`ifdef SCCB_ACK_CHECK_EN
        busy = busy && (s != StErr);
`endif
        return busy;
    endfunction

endpackage

// File: rtl/mt9d111_init_rom.sv
// Combinational sensor init table: index -> {reg_addr, reg_data}.
// Optional feature macro: SCCB_ACK_CHECK_EN (not used in this file).
module mt9d111_init_rom
    import mt9d111_pkg::*;
(
    input  logic [7:0]  index_i,
    output init_entry_t entry_o
);

    // Page select first, then read-mode setup; out-of-range indices read as zero.
    always_comb begin
        entry_o = '{reg_addr: 8'h00, reg_data: 16'h0000};
        case (index_i)
            8'd0:    entry_o = '{reg_addr: 8'hF0, reg_data: 16'h0001};
            8'd1:    entry_o = '{reg_addr: 8'h20, reg_data: 16'h0303};
            8'd2:    entry_o = '{reg_addr: 8'h21, reg_data: 16'h8400};
            default: ;
        endcase
    end

endmodule

// File: rtl/mt9d111_sccb_config.sv
// SCCB master that writes the MT9D111 init table after power-up.
// Optional feature macro: SCCB_ACK_CHECK_EN (NACK -> one retry, then sticky error).
module mt9d111_sccb_config
    import mt9d111_pkg::*;
#(
    parameter int unsigned CLK_DIV_Q    = 125,
    parameter int unsigned POWERUP_WAIT = 50000,
    parameter int unsigned GAP_WAIT     = 500
) (
    input  logic       CLOCK,
    input  logic       RESET_N,
    input  logic       START,
    output logic       SCCB_SCL,
    output logic       SCCB_SDA_OE,
    input  logic       SCCB_SDA_IN,
    output logic       CONFIG_BUSY,
    output logic       CONFIG_DONE,
    output logic       CONFIG_ERR,
    output logic [7:0] CONFIG_INDEX
);

    localparam int unsigned WaitMax   = (POWERUP_WAIT > GAP_WAIT) ? POWERUP_WAIT : GAP_WAIT;
    localparam int unsigned WaitW     = $clog2(WaitMax + 1);
    localparam int unsigned TickW     = $clog2(CLK_DIV_Q + 1);
    localparam logic [7:0]  LastIndex = 8'(INIT_LEN - 1);

    sccb_state_e       state_q, state_d;
    logic [TickW-1:0]  tick_q, tick_d;
    logic [1:0]        qtr_q, qtr_d;
    logic [2:0]        bit_q, bit_d;
    logic [1:0]        byte_q, byte_d;
    logic [WaitW-1:0]  wait_q, wait_d;
    logic [31:0]       frame_q, frame_d;
    logic [7:0]        index_q, index_d;
    logic              scl_q, scl_d;
    logic              sda_oe_q, sda_oe_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    init_entry_t       rom_entry;
    logic              tick;
    logic              bus_state;
    logic              next_bit;
    logic              nack_seen;

    mt9d111_init_rom u_rom (
        .index_i (index_q),
        .entry_o (rom_entry)
    );

`ifdef SCCB_ACK_CHECK_EN
    logic nack_q, nack_d;
    logic retry_q, retry_d;
    logic err_q, err_d;
    assign nack_seen  = nack_q;
    assign CONFIG_ERR = err_q;
`else
    logic unused_sda_in;
    assign unused_sda_in = SCCB_SDA_IN;
    assign nack_seen     = 1'b0;
    assign CONFIG_ERR    = 1'b0;
`endif

    assign tick      = (tick_q == TickW'(CLK_DIV_Q - 1));
    assign bus_state = state_q inside {StSta, StBit, StAck, StStp};

    // Next-state, counters and registered bus/status outputs.
    always_comb begin
        state_d  = state_q;
        tick_d   = '0;
        qtr_d    = qtr_q;
        bit_d    = bit_q;
        byte_d   = byte_q;
        wait_d   = '0;
        frame_d  = frame_q;
        index_d  = index_q;
        scl_d    = scl_q;
        sda_oe_d = sda_oe_q;
        next_bit = 1'b0;
`ifdef SCCB_ACK_CHECK_EN
        nack_d   = nack_q;
        retry_d  = retry_q;
`endif

        if (bus_state) begin
            tick_d = tick ? '0 : tick_q + TickW'(1);
            if (tick) begin
                qtr_d = qtr_q + 2'd1;
            end
        end

        unique case (state_q)
            StIdle, StDone: begin
                if (START) begin
                    index_d = '0;
                    state_d = StLoad;
                end
            end
            StPwrWait: begin
                if (wait_q == WaitW'(POWERUP_WAIT - 1)) begin
                    state_d = StLoad;
                end else begin
                    wait_d = wait_q + WaitW'(1);
                end
            end
            StLoad: begin
                // Leaving LOAD issues the START condition: SDA falls with SCL high.
                frame_d  = {SCCB_DEV_ADDR, rom_entry};
                bit_d    = '0;
                byte_d   = '0;
                qtr_d    = '0;
                scl_d    = 1'b1;
                sda_oe_d = 1'b1;
                state_d  = StSta;
`ifdef SCCB_ACK_CHECK_EN
                nack_d   = 1'b0;
`endif
            end
            StSta: begin
                if (tick) begin
                    state_d  = StBit;
                    next_bit = 1'b1;
                end
            end
            StBit: begin
                if (tick) begin
                    if (qtr_q == 2'd0) begin
                        scl_d = 1'b1;
                    end else if (qtr_q == 2'd3) begin
                        if (bit_q == 3'd7) begin
                            // ACK cell: SCL falls, SDA released for the whole cell.
                            bit_d    = '0;
                            scl_d    = 1'b0;
                            sda_oe_d = 1'b0;
                            state_d  = StAck;
                        end else begin
                            bit_d    = bit_q + 3'd1;
                            next_bit = 1'b1;
                        end
                    end
                end
            end
            StAck: begin
                if (tick) begin
                    if (qtr_q == 2'd0) begin
                        scl_d = 1'b1;
                    end else if (qtr_q == 2'd2) begin
`ifdef SCCB_ACK_CHECK_EN
                        nack_d = nack_q | SCCB_SDA_IN;
`endif
                    end else if (qtr_q == 2'd3) begin
                        if (byte_q == 2'd3 || nack_seen) begin
                            // STOP cell starts with SDA held low under a low SCL.
                            scl_d    = 1'b0;
                            sda_oe_d = 1'b1;
                            state_d  = StStp;
                        end else begin
                            byte_d   = byte_q + 2'd1;
                            state_d  = StBit;
                            next_bit = 1'b1;
                        end
                    end
                end
            end
            StStp: begin
                if (tick) begin
                    if (qtr_q == 2'd0) begin
                        scl_d = 1'b1;
                    end else if (qtr_q == 2'd1) begin
                        sda_oe_d = 1'b0;
                    end else if (qtr_q == 2'd3) begin
                        state_d = StGap;
                    end
                end
            end
            StGap: begin
                if (wait_q == WaitW'(GAP_WAIT - 1)) begin
                    if (nack_seen) begin
`ifdef SCCB_ACK_CHECK_EN
                        if (retry_q) begin
                            state_d = StErr;
                        end else begin
                            retry_d = 1'b1;
                            state_d = StLoad;
                        end
`endif
                    end else begin
`ifdef SCCB_ACK_CHECK_EN
                        retry_d = 1'b0;
`endif
                        if (index_q == LastIndex) begin
                            state_d = StDone;
                        end else begin
                            index_d = index_q + 8'd1;
                            state_d = StLoad;
                        end
                    end
                end else begin
                    wait_d = wait_q + WaitW'(1);
                end
            end
`ifdef SCCB_ACK_CHECK_EN
            StErr: begin
                if (START) begin
                    index_d = '0;
                    retry_d = 1'b0;
                    state_d = StLoad;
                end
            end
`endif
            default: state_d = StIdle;
        endcase

        // Q0 of a data bit: SCL falls and the next MSB is placed on SDA.
        if (next_bit) begin
            qtr_d    = '0;
            scl_d    = 1'b0;
            sda_oe_d = ~frame_q[31];
            frame_d  = {frame_q[30:0], 1'b0};
        end

        busy_d = state_busy(state_d);
        done_d = (state_d == StDone);
`ifdef SCCB_ACK_CHECK_EN
        err_d  = (state_d == StErr);
`endif
    end

    // State and output registers; reset parks the bus idle and re-arms the power-up wait.
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q  <= StPwrWait;
            tick_q   <= '0;
            qtr_q    <= '0;
            bit_q    <= '0;
            byte_q   <= '0;
            wait_q   <= '0;
            frame_q  <= '0;
            index_q  <= '0;
            scl_q    <= 1'b1;
            sda_oe_q <= 1'b0;
            busy_q   <= 1'b1;
            done_q   <= 1'b0;
`ifdef SCCB_ACK_CHECK_EN
            nack_q   <= 1'b0;
            retry_q  <= 1'b0;
            err_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            tick_q   <= tick_d;
            qtr_q    <= qtr_d;
            bit_q    <= bit_d;
            byte_q   <= byte_d;
            wait_q   <= wait_d;
            frame_q  <= frame_d;
            index_q  <= index_d;
            scl_q    <= scl_d;
            sda_oe_q <= sda_oe_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
`ifdef SCCB_ACK_CHECK_EN
            nack_q   <= nack_d;
            retry_q  <= retry_d;
            err_q    <= err_d;
`endif
        end
    end

    assign SCCB_SCL     = scl_q;
    assign SCCB_SDA_OE  = sda_oe_q;
    assign CONFIG_BUSY  = busy_q;
    assign CONFIG_DONE  = done_q;
    assign CONFIG_INDEX = index_q;

endmodule

// File: tb/tb_mt9d111_sccb_config.sv
// Bench for mt9d111_sccb_config: an SCCB bus monitor/slave decodes frames from the pins
// and compares them with the expected register table.
// Optional feature macro: SCCB_ACK_CHECK_EN (enables the NACK/retry scenario).
module tb_mt9d111_sccb_config;

    localparam int unsigned K    = 2;
    localparam int unsigned PW   = 10;
    localparam int unsigned GW   = 6;
    localparam int          NENT = 3;

    logic       CLOCK   = 1'b0;
    logic       RESET_N = 1'b0;
    logic       START   = 1'b0;
    logic       SCCB_SCL;
    logic       SCCB_SDA_OE;
    logic       SCCB_SDA_IN;
    logic       CONFIG_BUSY;
    logic       CONFIG_DONE;
    logic       CONFIG_ERR;
    logic [7:0] CONFIG_INDEX;

    mt9d111_sccb_config #(
        .CLK_DIV_Q    (K),
        .POWERUP_WAIT (PW),
        .GAP_WAIT     (GW)
    ) dut (
        .CLOCK        (CLOCK),
        .RESET_N      (RESET_N),
        .START        (START),
        .SCCB_SCL     (SCCB_SCL),
        .SCCB_SDA_OE  (SCCB_SDA_OE),
        .SCCB_SDA_IN  (SCCB_SDA_IN),
        .CONFIG_BUSY  (CONFIG_BUSY),
        .CONFIG_DONE  (CONFIG_DONE),
        .CONFIG_ERR   (CONFIG_ERR),
        .CONFIG_INDEX (CONFIG_INDEX)
    );

    always #5 CLOCK = ~CLOCK;

    // Expected table contents (the frame is {device, reg_addr, data_hi, data_lo}).
    logic [7:0]  exp_addr [NENT] = '{8'hF0, 8'h20, 8'h21};
    logic [15:0] exp_data [NENT] = '{16'h0001, 16'h0303, 16'h8400};

    int checks = 0;
    int errors = 0;

    // Open-drain SDA line: low if either the master or the slave pulls it.
    logic slave_low = 1'b0;
    logic sda_line;
    assign sda_line    = ~(SCCB_SDA_OE | slave_low);
    assign SCCB_SDA_IN = sda_line;

`ifdef SCCB_ACK_CHECK_EN
    logic       nack_en   = 1'b0;
    logic [7:0] nack_addr = 8'h00;
`endif

    // Monitor state
    int          cyc           = 0;
    logic        prev_scl      = 1'b1;
    logic        prev_sda      = 1'b1;
    logic        in_frame      = 1'b0;
    int          bitcnt        = 0;
    int          nbytes        = 0;
    logic [7:0]  shreg         = 8'h00;
    logic [31:0] fbuf          = 32'h0;
    int          frame_len [$];
    logic [31:0] frame_dat [$];
    int          first_fall    = -1;
    logic        early_act     = 1'b0;
    int          last_stop     = -1;
    int          min_gap       = 1000000;

    always @(posedge CLOCK) begin
        if (!RESET_N) cyc <= 0;
        else          cyc <= cyc + 1;
    end

    function automatic logic slave_acks(input int idx, input logic [7:0] b);
`ifdef SCCB_ACK_CHECK_EN
        return !(nack_en && idx == 1 && b == nack_addr);
`else
        // Acknowledge values must not matter in this build.
        if (idx < 0) return b[0];
        return ($urandom_range(0, 1) == 1);
`endif
    endfunction

    // Bus decoder and ACK-driving slave, sampled mid-cycle.
    always @(negedge CLOCK) begin
        logic scl;
        logic sda;
        scl = SCCB_SCL;
        sda = sda_line;
        if (!RESET_N) begin
            in_frame  = 1'b0;
            bitcnt    = 0;
            slave_low = 1'b0;
        end else if (prev_scl && scl && prev_sda && !sda) begin
            in_frame = 1'b1;
            bitcnt   = 0;
            nbytes   = 0;
            fbuf     = 32'h0;
            if (first_fall < 0) first_fall = cyc;
            if (last_stop >= 0 && (cyc - last_stop) < min_gap) min_gap = cyc - last_stop;
        end else if (prev_scl && scl && !prev_sda && sda) begin
            if (in_frame) begin
                frame_len.push_back(nbytes);
                frame_dat.push_back(fbuf);
            end
            in_frame  = 1'b0;
            last_stop = cyc;
        end else if (!prev_scl && scl && in_frame) begin
            if (bitcnt < 8) begin
                shreg  = {shreg[6:0], sda};
                bitcnt = bitcnt + 1;
            end else begin
                nbytes = nbytes + 1;
                fbuf   = {fbuf[23:0], shreg};
                bitcnt = 0;
            end
        end else if (prev_scl && !scl && in_frame) begin
            slave_low = (bitcnt == 8) && slave_acks(nbytes, shreg);
        end
        if (RESET_N && first_fall < 0 && (!scl || !sda)) early_act = 1'b1;
        prev_scl = scl;
        prev_sda = sda;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        frame_len.delete();
        frame_dat.delete();
        last_stop = -1;
        min_gap   = 1000000;
    endtask

    task automatic pulse_start();
        @(negedge CLOCK);
        START = 1'b1;
        @(negedge CLOCK);
        START = 1'b0;
    endtask

    task automatic release_reset();
        repeat (2) @(negedge CLOCK);
        clear_mon();
        first_fall = -1;
        early_act  = 1'b0;
        #1 RESET_N = 1'b1;
    endtask

    task automatic wait_end(input int max, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            @(negedge CLOCK);
            if (CONFIG_DONE || CONFIG_ERR) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic check_full_run(input string tag);
        check({tag, "_frame_count"}, frame_len.size(), NENT);
        for (int i = 0; i < frame_len.size() && i < NENT; i++) begin
            check($sformatf("%s_frame%0d_len", tag, i), frame_len[i], 4);
            check($sformatf("%s_frame%0d_bytes", tag, i), frame_dat[i],
                  {8'hBA, exp_addr[i], exp_data[i]});
        end
        check({tag, "_done"}, CONFIG_DONE, 1'b1);
        check({tag, "_busy"}, CONFIG_BUSY, 1'b0);
        check({tag, "_index"}, CONFIG_INDEX, 8'(NENT - 1));
        check({tag, "_scl_idle"}, SCCB_SCL, 1'b1);
        check({tag, "_sda_released"}, SCCB_SDA_OE, 1'b0);
        check({tag, "_gap"}, (min_gap >= int'(GW + 1)), 1'b1);
    endtask

    initial begin
        logic ok;

        // Reset values while held in reset
        repeat (3) @(negedge CLOCK);
        check("rst_scl", SCCB_SCL, 1'b1);
        check("rst_sda_oe", SCCB_SDA_OE, 1'b0);
        check("rst_busy", CONFIG_BUSY, 1'b1);
        check("rst_done", CONFIG_DONE, 1'b0);
        check("rst_err", CONFIG_ERR, 1'b0);
        check("rst_index", CONFIG_INDEX, 8'h00);

        // Run 1: power-up sequence; a START during the wait must be ignored
        release_reset();
        repeat (3) @(negedge CLOCK);
        check("pwr_busy", CONFIG_BUSY, 1'b1);
        pulse_start();
        wait_end(5000, ok);
        check("run1_finished", ok, 1'b1);
        check("first_sda_fall_cycle", first_fall, PW + 1);
        check("bus_quiet_before_start", early_act, 1'b0);
        check_full_run("run1");

        // Run 2: START from DONE restarts at entry 0; START pulses while busy are ignored
        clear_mon();
        pulse_start();
        check("restart_busy", CONFIG_BUSY, 1'b1);
        check("restart_done_clr", CONFIG_DONE, 1'b0);
        check("restart_index", CONFIG_INDEX, 8'h00);
        for (int n = 0; n < 4; n++) begin
            repeat ($urandom_range(20, 200)) @(negedge CLOCK);
            if (CONFIG_BUSY) pulse_start();
        end
        wait_end(5000, ok);
        check("run2_finished", ok, 1'b1);
        check_full_run("run2");

        // Run 3: reset in the middle of a byte
        clear_mon();
        pulse_start();
        repeat ($urandom_range(0, 600)) @(negedge CLOCK);
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge CLOCK);
            if (in_frame && bitcnt >= 2 && bitcnt <= 6) begin
                ok = 1'b1;
                break;
            end
        end
        check("mid_byte_reached", ok, 1'b1);
        #2 RESET_N = 1'b0;
        #1;
        check("midrst_scl", SCCB_SCL, 1'b1);
        check("midrst_sda_oe", SCCB_SDA_OE, 1'b0);
        check("midrst_busy", CONFIG_BUSY, 1'b1);
        check("midrst_index", CONFIG_INDEX, 8'h00);
        release_reset();
        wait_end(5000, ok);
        check("run3_finished", ok, 1'b1);
        check("midrst_first_fall_cycle", first_fall, PW + 1);
        check("midrst_bus_quiet", early_act, 1'b0);
        check_full_run("run3");

`ifdef SCCB_ACK_CHECK_EN
        // Run 4: slave NACKs the register address of entry 1 on both attempts
        clear_mon();
        nack_addr = exp_addr[1];
        nack_en   = 1'b1;
        pulse_start();
        wait_end(5000, ok);
        check("nack_finished", ok, 1'b1);
        check("nack_err", CONFIG_ERR, 1'b1);
        check("nack_done", CONFIG_DONE, 1'b0);
        check("nack_busy", CONFIG_BUSY, 1'b0);
        check("nack_index", CONFIG_INDEX, 8'h01);
        check("nack_scl_idle", SCCB_SCL, 1'b1);
        check("nack_sda_released", SCCB_SDA_OE, 1'b0);
        check("nack_frame_count", frame_len.size(), 3);
        if (frame_len.size() == 3) begin
            check("nack_frame0", frame_dat[0], {8'hBA, exp_addr[0], exp_data[0]});
            check("nack_frame1_len", frame_len[1], 2);
            check("nack_frame1", frame_dat[1], {16'h0, 8'hBA, exp_addr[1]});
            check("nack_frame2_len", frame_len[2], 2);
            check("nack_frame2", frame_dat[2], {16'h0, 8'hBA, exp_addr[1]});
        end
        nack_en = 1'b0;
        clear_mon();
        pulse_start();
        check("err_cleared", CONFIG_ERR, 1'b0);
        check("err_restart_index", CONFIG_INDEX, 8'h00);
        wait_end(5000, ok);
        check("run5_finished", ok, 1'b1);
        check_full_run("run5");
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
